// File: rtl/alarm_annunciator.sv
// Alarm annunciator: latches siren/lamp requests, drives tone and blink patterns,
// and handles operator silencing. Optional event counter: ALARM_ANNUNCIATOR_EVENT_CNT_EN.
module alarm_annunciator #(
    parameter int unsigned TONE_DIV       = 2,
    parameter int unsigned BLINK_DIV      = 4,
    parameter int unsigned SILENCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       siren_on,
    input  logic       alert_light,
    input  logic       ack,
    output logic       siren_out,
    output logic       light_out,
    output logic [1:0] state,
    output logic [1:0] latched
`ifdef ALARM_ANNUNCIATOR_EVENT_CNT_EN
    ,
    output logic [7:0] event_cnt
`endif
);

    localparam int unsigned TW = $clog2(TONE_DIV + 1);
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam int unsigned SW = $clog2(SILENCE_CYCLES + 1);
    localparam logic [TW-1:0] TONE_RELOAD  = TW'(TONE_DIV - 1);
    localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SIL_RELOAD   = SW'(SILENCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ALARM    = 2'd1,
        ST_SILENCED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          siren_latch_q, siren_latch_d;
    logic          light_latch_q, light_latch_d;
    logic          siren_q;
    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          tone_ph_q, tone_ph_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [SW-1:0] sil_cnt_q, sil_cnt_d;

    logic any_req;
    logic rearm;
    assign any_req = siren_on | alert_light;
    assign rearm   = (siren_on & ~siren_q) | ((sil_cnt_q == '0) & any_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            siren_latch_q <= 1'b0;
            light_latch_q <= 1'b0;
            siren_q       <= 1'b0;
            tone_cnt_q    <= '0;
            tone_ph_q     <= 1'b0;
            blink_cnt_q   <= '0;
            blink_ph_q    <= 1'b0;
            sil_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            siren_latch_q <= siren_latch_d;
            light_latch_q <= light_latch_d;
            siren_q       <= siren_on;
            tone_cnt_q    <= tone_cnt_d;
            tone_ph_q     <= tone_ph_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_ph_q    <= blink_ph_d;
            sil_cnt_q     <= sil_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        siren_latch_d = siren_latch_q;
        light_latch_d = light_latch_q;
        tone_cnt_d    = tone_cnt_q;
        tone_ph_d     = tone_ph_q;
        blink_cnt_d   = blink_cnt_q;
        blink_ph_d    = blink_ph_q;
        sil_cnt_d     = sil_cnt_q;
        case (state_q)
            ST_ALARM: begin
                siren_latch_d = siren_latch_q | siren_on;
                light_latch_d = light_latch_q | alert_light;
                if (tone_cnt_q == '0) begin
                    tone_ph_d  = ~tone_ph_q;
                    tone_cnt_d = TONE_RELOAD;
                end else begin
                    tone_cnt_d = tone_cnt_q - TW'(1);
                end
                if (blink_cnt_q == '0) begin
                    blink_ph_d  = ~blink_ph_q;
                    blink_cnt_d = BLINK_RELOAD;
                end else begin
                    blink_cnt_d = blink_cnt_q - BW'(1);
                end
                if (ack) begin
                    state_d   = ST_SILENCED;
                    sil_cnt_d = SIL_RELOAD;
                end
            end
            ST_SILENCED: begin
                siren_latch_d = siren_latch_q | siren_on;
                light_latch_d = light_latch_q | alert_light;
                if (rearm) begin
                    state_d     = ST_ALARM;
                    tone_ph_d   = 1'b1;
                    blink_ph_d  = 1'b1;
                    tone_cnt_d  = TONE_RELOAD;
                    blink_cnt_d = BLINK_RELOAD;
                end else if (sil_cnt_q == '0) begin
                    state_d       = ST_IDLE;
                    siren_latch_d = 1'b0;
                    light_latch_d = 1'b0;
                end else if (ack) begin
                    sil_cnt_d = SIL_RELOAD;
                end else begin
                    sil_cnt_d = sil_cnt_q - SW'(1);
                end
            end
            default: begin
                // IDLE and the unused encoding: track inputs, keep patterns primed
                siren_latch_d = siren_on;
                light_latch_d = alert_light;
                tone_ph_d     = 1'b1;
                blink_ph_d    = 1'b1;
                tone_cnt_d    = TONE_RELOAD;
                blink_cnt_d   = BLINK_RELOAD;
                if (any_req) state_d = ST_ALARM;
            end
        endcase
    end

`ifdef ALARM_ANNUNCIATOR_EVENT_CNT_EN
    // Counts fresh alarms only; re-arms out of SILENCED are excluded
    logic first_entry;
    assign first_entry = (state_q != ST_ALARM) && (state_q != ST_SILENCED) && any_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_cnt <= 8'd0;
        end else if (first_entry && (event_cnt != 8'hFF)) begin
            event_cnt <= event_cnt + 8'd1;
        end
    end
`endif

    assign state     = state_q;
    assign latched   = {light_latch_q, siren_latch_q};
    assign siren_out = (state_q == ST_ALARM) & siren_latch_q & tone_ph_q;

    always_comb begin
        case (state_q)
            ST_ALARM:    light_out = light_latch_q & blink_ph_q;
            ST_SILENCED: light_out = 1'b1;
            default:     light_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alarm_annunciator.sv
// Scoreboard bench for alarm_annunciator: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_alarm_annunciator;

    localparam int TD = 2;
    localparam int BD = 4;
    localparam int SC = 16;

    logic       clk;
    logic       rst;
    logic       siren_on;
    logic       alert_light;
    logic       ack;
    logic       siren_out;
    logic       light_out;
    logic [1:0] state;
    logic [1:0] latched;
`ifdef ALARM_ANNUNCIATOR_EVENT_CNT_EN
    logic [7:0] event_cnt;
`endif

    alarm_annunciator #(
        .TONE_DIV(TD),
        .BLINK_DIV(BD),
        .SILENCE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .siren_on(siren_on),
        .alert_light(alert_light),
        .ack(ack),
        .siren_out(siren_out),
        .light_out(light_out),
        .state(state),
        .latched(latched)
`ifdef ALARM_ANNUNCIATOR_EVENT_CNT_EN
        ,
        .event_cnt(event_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] lat;
        logic       so;
        logic       lo;
        logic [7:0] ev;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Model: ALARM patterns are derived from the age since entry, not from counters
    int m_st, m_age, m_sil, m_ev;
    bit m_sl, m_ll, m_sq;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_age = 0; m_sil = 0; m_ev = 0;
        m_sl = 0; m_ll = 0; m_sq = 0;
    endtask

    task automatic model_edge(input bit s, input bit a, input bit k);
        case (m_st)
            1: begin
                m_sl |= s; m_ll |= a;
                if (k) begin m_st = 2; m_sil = SC - 1; end
                else m_age++;
            end
            2: begin
                m_sl |= s; m_ll |= a;
                if ((s && !m_sq) || (m_sil == 0 && (s || a))) begin
                    m_st = 1; m_age = 0;
                end else if (m_sil == 0) begin
                    m_st = 0; m_sl = 0; m_ll = 0;
                end else if (k) m_sil = SC - 1;
                else m_sil--;
            end
            default: begin
                m_sl = s; m_ll = a;
                if (s || a) begin
                    m_st = 1; m_age = 0;
                    if (m_ev < 255) m_ev++;
                end
            end
        endcase
        m_sq = s;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st  = 2'(m_st);
        e.lat = {m_ll, m_sl};
        e.so  = (m_st == 1) && m_sl && (((m_age / TD) % 2) == 0);
        e.lo  = (m_st == 2) || ((m_st == 1) && m_ll && (((m_age / BD) % 2) == 0));
        e.ev  = 8'(m_ev);
        return e;
    endfunction

    task automatic compare_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 8'd1, 8'd0);
            return;
        end
        e = exp_q.pop_front();
        check("state", {6'd0, state}, {6'd0, e.st});
        check("latched", {6'd0, latched}, {6'd0, e.lat});
        check("siren_out", {7'd0, siren_out}, {7'd0, e.so});
        check("light_out", {7'd0, light_out}, {7'd0, e.lo});
`ifdef ALARM_ANNUNCIATOR_EVENT_CNT_EN
        check("event_cnt", event_cnt, e.ev);
`endif
    endtask

    task automatic step(input bit s, input bit a, input bit k);
        @(negedge clk);
        siren_on = s; alert_light = a; ack = k;
        model_edge(s, a, k);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic async_reset();
        @(negedge clk);
        siren_on = 0; alert_light = 0; ack = 0;
        rst = 1'b1;
        model_reset();
        exp_q.push_back(model_out());
        #1;
        compare_pop();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; siren_on = 0; alert_light = 0; ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model_out());
        compare_pop();
        @(negedge clk);
        rst = 1'b0;
        idle_n(3);

        // Single-cycle siren pulse: latched, tone pattern persists
        step(1, 0, 0);
        idle_n(9);
        // New lamp request while alarming, then ack: SILENCED for SC cycles, then IDLE
        step(0, 1, 0);
        idle_n(2);
        step(0, 0, 1);
        idle_n(SC + 2);

        // ack together with a new input in ALARM: ack wins, input still latched
        step(1, 0, 0);
        step(0, 1, 1);
        idle_n(4);
        // Siren rising edge with ack at cycle 5 of SILENCED re-arms
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        idle_n(SC + 1);

        // Persisting lamp request through a full silence window
        step(0, 1, 0);
        step(0, 1, 1);
        for (int i = 0; i < SC + 10; i++) step(0, 1, 0);
        step(0, 0, 1);

        // ack held continuously keeps SILENCED; release lets it expire
        for (int i = 0; i < 40; i++) step(0, 0, 1);
        idle_n(SC + 2);

        // Reset mid-ALARM
        step(1, 1, 0);
        idle_n(3);
        async_reset();
        idle_n(4);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 11) == 0),
                 bit'($urandom_range(0, 5) == 0));

        async_reset();
        idle_n(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bound expired");
        $fatal(1);
    end

endmodule

// File: doc/alarm_annunciator.md
# alarm_annunciator

Receiving end of the alarm controller's output interface. Takes `siren_on` and `alert_light` and drives the physical siren tone and the warning lamp. Latches every alarm until an operator acknowledges it, enforces a silence window, and re-sounds if a condition persists or a new event arrives. Sits between the alarm controller and the output drivers.

## Interface
- `TONE_DIV`, default 2: cycles per siren half-period (≥1)
- `BLINK_DIV`, default 4: cycles per lamp half-period (≥1)
- `SILENCE_CYCLES`, default 16: length of the silence window in cycles (≥1)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high; one clock, no other clock domains
- `siren_on`  in  1  siren request from the alarm controller
- `alert_light`  in  1  lamp request from the alarm controller
- `ack`  in  1  operator acknowledge, level-sampled
- `siren_out`  out  1  siren drive (tone pattern)
- `light_out`  out  1  lamp drive
- `state`  out  2  0=IDLE, 1=ALARM, 2=SILENCED (3 unused, decodes as IDLE)
- `latched`  out  2  {light_latch, siren_latch}

## Operation
- Registers:
  - state
  - latches
  - `siren_q`, the previous `siren_on`
  - tone_cnt/tone_ph
  - blink_cnt/blink_ph
  - sil_cnt (width clog2(SILENCE_CYCLES+1))
- All outputs decode from registers only; there is no combinational input-to-output path.
- `siren_out` = (state==ALARM) & siren_latch & tone_ph.
- `light_out`:
  - ALARM: light_latch & blink_ph.
  - SILENCED: 1.
  - IDLE: 0.
- IDLE:
  - `siren_on|alert_light` high → ALARM.
  - Latches load the current inputs.
  - tone_ph=blink_ph=1, tone_cnt=TONE_DIV-1, blink_cnt=BLINK_DIV-1.
- ALARM:
  - Latches |= inputs every cycle. Deasserting an input never clears its latch.
  - Each phase counter decrements. At 0 it toggles its phase and reloads DIV-1.
  - `ack` high → SILENCED with sil_cnt=SILENCE_CYCLES-1. ack wins over simultaneous new inputs, but those inputs are still ORed into the latches.
- SILENCED:
  - Latches |= inputs.
  - Re-arm to ALARM if either holds:
    - siren rising edge (`siren_on & ~siren_q`);
    - sil_cnt==0 and `siren_on|alert_light` high.
  - Re-arm reloads phases and counters as on IDLE entry.
  - sil_cnt==0 with both inputs low → IDLE and clear latches.
  - Otherwise, `ack` high → reload sil_cnt=SILENCE_CYCLES-1.
  - Otherwise, decrement sil_cnt.
  - Priority: re-arm > expiry-to-IDLE > ack reload > decrement.
- Reset mid-operation aborts immediately: all registers return to reset values and no pending state survives.

## Timing
- Reset values:
  - state=IDLE, latched=00
  - siren_out=0, light_out=0
  - counters=0, phases=0, siren_q=0
- Latency: input high before edge k → state=ALARM and outputs active after edge k.
- A one-cycle input pulse is sufficient to latch.
- Siren pattern from ALARM entry is TONE_DIV cycles high, then TONE_DIV low, repeating. Lamp pattern uses BLINK_DIV the same way.
- `ack` high at edge k in ALARM → SILENCED after edge k, siren_out=0 and light_out=1 from that cycle.
- SILENCED lasts exactly SILENCE_CYCLES cycles when no ack or event occurs. Each ack extends it to SILENCE_CYCLES cycles from that ack.
- Holding ack high continuously keeps SILENCED indefinitely.
- A siren rising edge at edge k in SILENCED → ALARM after edge k, even if ack is high on the same edge.

## Configuration
- `ALARM_ANNUNCIATOR_EVENT_CNT_EN` defined:
  - Adds output `event_cnt` (out, 8).
  - Increments on each IDLE→ALARM transition; SILENCED→ALARM re-arms do not count.
  - Saturates at 255. Resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset: assert `rst` mid-ALARM → state=0, latched=00, siren_out=0, light_out=0 asynchronously; outputs stay 0 after release with inputs low.
- Siren latch: `siren_on`=1 for one cycle → state=1 next edge, latched=01, siren_out 1,1,0,0,1,1…, light_out=0, persisting after input drops.
- Ack/expiry: latch both, pulse `ack` → state=2, siren_out=0, light_out=1 for 16 cycles; inputs low → state=0, latched=00.
- Re-arm on edge: in SILENCED, raise `siren_on` at cycle 5 together with `ack` → state=1 next edge, siren pattern restarts high.
- Persisting condition: `alert_light` held high through a 16-cycle silence → expiry returns to state=1, light_out 4 high/4 low.
- Macro on: three separate alarm/ack/expire episodes → event_cnt=3; a re-arm inside SILENCED does not increment; `rst` → event_cnt=0.
